// File: rtl/ariane_pkg.sv
// ---------------------------------------------------------------------------
// ariane_pkg (slice)
// Shared core types used by the fetch/decode boundary: exception record,
// branch-prediction side band and the fetch entry handed from IF to ID.
// No ports; imported by the fetch-entry queue and its realigner.
// ---------------------------------------------------------------------------
package ariane_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned VLEN = 64;

  typedef enum logic [2:0] {
    NoCF,
    Branch,
    Jump,
    JumpR,
    Return
  } cf_t;

  typedef struct packed {
    cf_t             cf;
    logic [VLEN-1:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [VLEN-1:0]    address;
    logic [31:0]        instruction;
    branchpredict_sbe_t branch_predict;
    exception_t         ex;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_entry_queue_pkg
// Constants and helpers shared by the fetch-entry queue and its realigner:
// the compressed-instruction test and a builder for a clean fetch entry.
// No ports.
// ---------------------------------------------------------------------------
package fetch_entry_queue_pkg;

  import ariane_pkg::*;

  // Opcode bits [1:0] == 2'b11 marks a full 32-bit instruction.
  localparam logic [1:0] UNCOMP_OP = 2'b11;

  function automatic logic is_compressed(input logic [15:0] half);
    return half[1:0] != UNCOMP_OP;
  endfunction

  // Entry with no exception and no predicted control flow.
  function automatic fetch_entry_t mk_entry(input logic [VLEN-1:0] addr,
                                            input logic [31:0]     instr);
    fetch_entry_t e;
    e                   = '0;
    e.address           = addr;
    e.instruction       = instr;
    e.branch_predict.cf = NoCF;
    return e;
  endfunction

endpackage

// File: rtl/fetch_realigner.sv
// ---------------------------------------------------------------------------
// fetch_realigner
// Splits one accepted 32-bit fetch word into up to two fetch entries in
// program order and keeps the upper half of a straddling 32-bit instruction
// until the next word arrives.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   i_flush         drop the pending half
//   i_accept        a fetch word is handed over this cycle
//   i_data/i_addr   fetch word and address of its first useful halfword
//   i_ex_valid      fetch faulted; i_ex_cause gives the cause
//   o_valid[1:0]    entry slots carrying an instruction (slot 0 first)
//   o_entry[1:0]    the entries, slot 0 older than slot 1
// ---------------------------------------------------------------------------
module fetch_realigner
  import ariane_pkg::*;
  import fetch_entry_queue_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   i_flush,
  input  logic                   i_accept,
  input  logic [31:0]            i_data,
  input  logic [VLEN-1:0]        i_addr,
  input  logic                   i_ex_valid,
  input  logic [XLEN-1:0]        i_ex_cause,
  output logic [1:0]             o_valid,
  output fetch_entry_t [1:0]     o_entry
);

  logic            r_pend_valid;
  logic [15:0]     r_pend_half;
  logic [VLEN-1:0] r_pend_addr;

  logic            w_pend_valid_n;
  logic [15:0]     w_pend_half_n;
  logic [VLEN-1:0] w_pend_addr_n;

  logic [VLEN-1:0] w_word;
  logic [VLEN-1:0] w_upper;
  logic [15:0]     w_lo;
  logic [15:0]     w_hi;
  logic            w_use_upper;
  logic            w_upper_slot;

  assign w_word  = {i_addr[VLEN-1:2], 2'b00};
  assign w_upper = w_word + VLEN'(2);
  assign w_lo    = i_data[15:0];
  assign w_hi    = i_data[31:16];

  always_comb begin
    o_valid        = '0;
    o_entry[0]     = '0;
    o_entry[1]     = '0;
    w_pend_valid_n = r_pend_valid;
    w_pend_half_n  = r_pend_half;
    w_pend_addr_n  = r_pend_addr;
    w_use_upper    = 1'b0;
    w_upper_slot   = 1'b0;

    if (i_accept) begin
      w_pend_valid_n = 1'b0;
      if (i_ex_valid) begin
        // A fault consumes the word as a single entry, attributed to the
        // start of the straddling instruction when one is pending.
        o_valid[0]            = 1'b1;
        o_entry[0]            = mk_entry(r_pend_valid ? r_pend_addr : i_addr, 32'h0);
        o_entry[0].ex.valid   = 1'b1;
        o_entry[0].ex.cause   = i_ex_cause;
        o_entry[0].ex.tval    = i_addr;
      end else if (i_addr[1]) begin
        // Entry at the upper half (a jump target): any pending half is stale.
        w_use_upper  = 1'b1;
        w_upper_slot = 1'b0;
      end else if (r_pend_valid) begin
        o_valid[0]   = 1'b1;
        o_entry[0]   = mk_entry(r_pend_addr, {w_lo, r_pend_half});
        w_use_upper  = 1'b1;
        w_upper_slot = 1'b1;
      end else if (is_compressed(w_lo)) begin
        o_valid[0]   = 1'b1;
        o_entry[0]   = mk_entry(w_word, {16'h0, w_lo});
        w_use_upper  = 1'b1;
        w_upper_slot = 1'b1;
      end else begin
        o_valid[0]   = 1'b1;
        o_entry[0]   = mk_entry(w_word, i_data);
      end

      if (w_use_upper) begin
        if (is_compressed(w_hi)) begin
          if (w_upper_slot) begin
            o_valid[1] = 1'b1;
            o_entry[1] = mk_entry(w_upper, {16'h0, w_hi});
          end else begin
            o_valid[0] = 1'b1;
            o_entry[0] = mk_entry(w_upper, {16'h0, w_hi});
          end
        end else begin
          w_pend_valid_n = 1'b1;
          w_pend_half_n  = w_hi;
          w_pend_addr_n  = w_upper;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend_valid <= 1'b0;
      r_pend_half  <= '0;
      r_pend_addr  <= '0;
    end else if (i_flush) begin
      r_pend_valid <= 1'b0;
    end else begin
      r_pend_valid <= w_pend_valid_n;
      r_pend_half  <= w_pend_half_n;
      r_pend_addr  <= w_pend_addr_n;
    end
  end

endmodule

// File: rtl/fetch_entry_queue.sv
// ---------------------------------------------------------------------------
// fetch_entry_queue
// IF->ID fetch-entry producer: realigns fetch words into per-instruction
// entries and buffers them in a DEPTH-entry FIFO drained by decode.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                drop buffered entries and the pending half
//   fetch_valid_i/ready_o  fetch word handshake
//   fetch_data_i/addr_i    fetch word and address of first halfword used
//   fetch_ex_valid_i/cause fetch fault indication
//   fetch_entry_o          FIFO head
//   fetch_entry_valid_o    FIFO not empty
//   fetch_entry_ready_i    decode consumes the head
// ---------------------------------------------------------------------------
module fetch_entry_queue
  import ariane_pkg::*;
  import fetch_entry_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [31:0]     fetch_data_i,
  input  logic [VLEN-1:0] fetch_addr_i,
  input  logic            fetch_ex_valid_i,
  input  logic [XLEN-1:0] fetch_ex_cause_i,
  output fetch_entry_t    fetch_entry_o,
  output logic            fetch_entry_valid_o,
  input  logic            fetch_entry_ready_i
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic             w_accept;
  logic [1:0]       w_rv;
  fetch_entry_t [1:0] w_re;
  logic [1:0]       w_push;
  logic [1:0]       w_npush;
  logic             w_pop;
  logic [CW:0]      w_free;

  // Ready needs room for a two-entry word; a pop in the same cycle is not
  // credited, keeping this off any combinational path from decode.
  assign w_free        = (CW+1)'(DEPTH) - {1'b0, r_count};
  assign fetch_ready_o = w_free >= (CW+1)'(2);
  assign w_accept      = fetch_valid_i & fetch_ready_o;

  fetch_realigner u_realign (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_flush    (flush_i),
    .i_accept   (w_accept),
    .i_data     (fetch_data_i),
    .i_addr     (fetch_addr_i),
    .i_ex_valid (fetch_ex_valid_i),
    .i_ex_cause (fetch_ex_cause_i),
    .o_valid    (w_rv),
    .o_entry    (w_re)
  );

  assign w_push  = flush_i ? 2'b00 : w_rv;
  assign w_npush = {1'b0, w_push[0]} + {1'b0, w_push[1]};
  assign w_pop   = (r_count != '0) && fetch_entry_ready_i && !flush_i;

  assign fetch_entry_valid_o = (r_count != '0);
  assign fetch_entry_o       = r_mem[r_rd_ptr];

  // Slot 1 is only ever valid together with slot 0, so it lands at wr+1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push[0]) r_mem[r_wr_ptr]           <= w_re[0];
      if (w_push[1]) r_mem[r_wr_ptr + PW'(1)]  <= w_re[1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_npush);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count  <= r_count + CW'(w_npush) - CW'(w_pop);
    end
  end

endmodule
